fir_out_fifo: RTL and testbench

- AXI-Stream buffer directly downstream of the FIR output stream (sm_tvalid/sm_tdata/sm_tlast/sm_tready).
- Decouples FIR output from a stalling consumer.
- Tracks frame boundaries via tlast, counts delivered frames, and checks each frame's length against the configured data length (the value in config register 0x10).

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_fifo_mem.sv | 25 ++
 rtl/fir_out_fifo.sv | 141 ++++++++++++++
 tb/tb_fir_out_fifo.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants: stream width, AXI-Lite register map, ap_ctrl bits.
// Also holds the frame-length compare used by the output buffer.
package fir_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_DATA_LEN = 8'h10;
    localparam logic [7:0] ADDR_TAP_LEN  = 8'h14;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    // True when a frame closed by the word now arriving (cnt words seen
    // before it) does not have the configured length.
    function automatic logic len_mismatch(
        input logic [31:0] cnt,
        input logic [31:0] exp_len
    );
        return (cnt + 32'd1) != exp_len;
    endfunction

endpackage

// File: rtl/fir_fifo_mem.sv
// Register-array FIFO storage: synchronous write, combinational read.
// Ports: i_clk, i_we/i_waddr/i_wdata write side, i_raddr/o_rdata read side.
module fir_fifo_mem #(
    parameter int pWIDTH = 33,
    parameter int pAW    = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [pAW-1:0]    i_waddr,
    input  logic [pWIDTH-1:0] i_wdata,
    input  logic [pAW-1:0]    i_raddr,
    output logic [pWIDTH-1:0] o_rdata
);

    logic [pWIDTH-1:0] r_mem [2**pAW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// AXI-Stream output buffer behind the FIR: FWFT registered output, frame
// counting on output tlast, and length check of each input frame.
// Ports: axis_clk/axis_rst_n; s_* input stream; m_* output stream;
// exp_len expected frame length; clr clears frame_cnt/len_err;
// level occupancy; frame_cnt frames emitted; len_err sticky; frame_done pulse.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH,
    parameter int pDEPTH_LOG2 = 4,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic [31:0]            exp_len,
    input  logic                   clr,
    output logic [pDEPTH_LOG2:0]   level,
    output logic [pCNT_WIDTH-1:0]  frame_cnt,
    output logic                   len_err,
    output logic                   frame_done
);

    localparam int AW1   = pDEPTH_LOG2 + 1;
    localparam int DEPTH = 2**pDEPTH_LOG2;

    logic [AW1-1:0]          r_wr_ptr;
    logic [AW1-1:0]          r_rd_ptr;
    logic                    r_s_tready;
    logic                    r_m_tvalid;
    logic [pDATA_WIDTH-1:0]  r_m_tdata;
    logic                    r_m_tlast;
    logic [31:0]             r_rx_cnt;
    logic [pCNT_WIDTH-1:0]   r_frame_cnt;
    logic                    r_len_err;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_fdone;
    logic [AW1-1:0]          w_level;
    logic [AW1-1:0]          w_level_pop;
    logic [AW1-1:0]          w_level_nxt;
    logic [AW1-1:0]          w_rd_nxt;
    logic [pDATA_WIDTH:0]    w_rdata;

    assign w_push      = s_tvalid && r_s_tready;
    assign w_pop       = r_m_tvalid && m_tready;
    assign w_fdone     = w_pop && r_m_tlast;
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign w_level_pop = w_level - AW1'(w_pop);
    assign w_level_nxt = w_level_pop + AW1'(w_push);
    assign w_rd_nxt    = r_rd_ptr + AW1'(w_pop);

    // The head entry stays in memory; the output register mirrors the
    // entry at the post-pop read pointer, so the read address looks ahead.
    fir_fifo_mem #(
        .pWIDTH (pDATA_WIDTH + 1),
        .pAW    (pDEPTH_LOG2)
    ) u_mem (
        .i_clk   (axis_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[pDEPTH_LOG2-1:0]),
        .i_wdata ({s_tlast, s_tdata}),
        .i_raddr (w_rd_nxt[pDEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW1'(w_push);
            r_rd_ptr   <= w_rd_nxt;
            // Registered from next occupancy: a pop while full only
            // reopens the input one cycle later.
            r_s_tready <= (w_level_nxt != AW1'(DEPTH));
            r_m_tvalid <= (w_level_nxt != '0);
            if (w_level_pop == '0) begin
                // Memory is empty after the pop: a word arriving now
                // bypasses straight into the output register.
                if (w_push) begin
                    r_m_tdata <= s_tdata;
                    r_m_tlast <= s_tlast;
                end
            end else begin
                r_m_tdata <= w_rdata[pDATA_WIDTH-1:0];
                r_m_tlast <= w_rdata[pDATA_WIDTH];
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_rx_cnt    <= '0;
            r_frame_cnt <= '0;
            r_len_err   <= 1'b0;
        end else begin
            if (w_push) begin
                if (s_tlast) begin
                    r_rx_cnt <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 32'd1;
                end
            end
            // Events take priority over a coincident clear.
            if (w_push && s_tlast && len_mismatch(r_rx_cnt, exp_len)) begin
                r_len_err <= 1'b1;
            end else if (clr) begin
                r_len_err <= 1'b0;
            end
            if (w_fdone) begin
                r_frame_cnt <= clr ? pCNT_WIDTH'(1)
                                   : r_frame_cnt + pCNT_WIDTH'(1);
            end else if (clr) begin
                r_frame_cnt <= '0;
            end
        end
    end

    assign s_tready   = r_s_tready;
    assign m_tvalid   = r_m_tvalid;
    assign m_tdata    = r_m_tdata;
    assign m_tlast    = r_m_tlast;
    assign level      = w_level;
    assign frame_cnt  = r_frame_cnt;
    assign len_err    = r_len_err;
    assign frame_done = w_fdone;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: cycle table plus multi-cycle sequences,
// with a queue scoreboard on the output stream.
module tb_fir_out_fifo;

    logic        axis_clk;
    logic        axis_rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [31:0] exp_len;
    logic        clr;
    logic [4:0]  level;
    logic [15:0] frame_cnt;
    logic        len_err;
    logic        frame_done;

    fir_out_fifo dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .exp_len    (exp_len),
        .clr        (clr),
        .level      (level),
        .frame_cnt  (frame_cnt),
        .len_err    (len_err),
        .frame_done (frame_done)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_fd  = 0;
    logic [32:0] sbq [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest accepted word.
    always @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            sbq.delete();
        end else begin
            if (frame_done) n_fd++;
            if (m_tvalid && m_tready) begin
                n_pop++;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    chk("sb_data", 64'({m_tlast, m_tdata}),
                        64'(sbq.pop_front()));
                end
            end
            if (s_tvalid && s_tready) sbq.push_back({s_tlast, s_tdata});
        end
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        mr;
        logic        cl;
        logic        mv;
        logic        cd;
        logic [31:0] md;
        logic        ml;
        logic [4:0]  lvl;
        logic        fd;
        logic [15:0] fc;
        logic        le;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(
        input logic v, input logic [31:0] d, input logic l,
        input logic mr, input logic cl, input logic mv, input logic cd,
        input logic [31:0] md, input logic ml, input logic [4:0] lvl,
        input logic fd, input logic [15:0] fc, input logic le);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.mr = mr; t.cl = cl;
        t.mv = mv; t.cd = cd; t.md = md; t.ml = ml; t.lvl = lvl;
        t.fd = fd; t.fc = fc; t.le = le;
        return t;
    endfunction

    task automatic push_word(input logic [31:0] d, input logic l);
        int   n;
        logic r;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        n = 0;
        do begin
            @(negedge axis_clk);
            r = s_tready;
            @(posedge axis_clk);
            #1;
            n++;
        end while (!r && n < 200);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("push_accept", 64'(r), 64'(1));
    endtask

    task automatic drain();
        int n;
        m_tready = 1'b1;
        n = 0;
        @(negedge axis_clk);
        while ((level != 0 || m_tvalid) && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        chk("drain_done", 64'(level), 64'(0));
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base);
        for (int i = 1; i <= n; i++) push_word(base + 32'(i), i == n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int acc;
        int p0;
        int f0;
        logic r;
        logic done;

        axis_rst_n = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready = 1'b0; exp_len = 32'd3; clr = 1'b0;

        tbl[0]  = mk(1, 32'h11, 0, 0, 0, 0, 1, 32'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h22, 0, 0, 0, 1, 1, 32'h11, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 32'h33, 1, 1, 0, 1, 1, 32'h11, 0, 2, 0, 0, 0);
        tbl[3]  = mk(0, 32'h00, 0, 1, 0, 1, 1, 32'h22, 0, 2, 0, 0, 0);
        tbl[4]  = mk(0, 32'h00, 0, 1, 0, 1, 1, 32'h33, 1, 1, 1, 0, 0);
        tbl[5]  = mk(0, 32'h00, 0, 1, 1, 0, 0, 32'h00, 0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 32'h44, 1, 0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 32'h00, 0, 0, 1, 1, 1, 32'h44, 1, 1, 0, 0, 1);
        tbl[8]  = mk(0, 32'h00, 0, 1, 1, 1, 1, 32'h44, 1, 1, 1, 0, 0);
        tbl[9]  = mk(0, 32'h00, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 1, 0);
        tbl[10] = mk(1, 32'h55, 1, 0, 1, 0, 0, 32'h00, 0, 0, 0, 1, 0);
        tbl[11] = mk(0, 32'h00, 0, 0, 0, 1, 1, 32'h55, 1, 1, 0, 0, 1);
        tbl[12] = mk(0, 32'h00, 0, 1, 1, 1, 1, 32'h55, 1, 1, 1, 0, 1);
        tbl[13] = mk(0, 32'h00, 0, 0, 0, 0, 0, 32'h00, 0, 0, 0, 1, 0);

        // Reset state
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        @(posedge axis_clk);
        #1;

        // Cycle table: latency, hold, clr-vs-event priority
        for (int i = 0; i < 14; i++) begin
            s_tvalid = tbl[i].v;
            s_tdata  = tbl[i].d;
            s_tlast  = tbl[i].l;
            m_tready = tbl[i].mr;
            clr      = tbl[i].cl;
            @(negedge axis_clk);
            chk($sformatf("t%0d_s_tready", i), 64'(s_tready), 64'(1));
            chk($sformatf("t%0d_m_tvalid", i), 64'(m_tvalid), 64'(tbl[i].mv));
            if (tbl[i].cd) begin
                chk($sformatf("t%0d_m_tdata", i), 64'(m_tdata), 64'(tbl[i].md));
                chk($sformatf("t%0d_m_tlast", i), 64'(m_tlast), 64'(tbl[i].ml));
            end
            chk($sformatf("t%0d_level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("t%0d_fdone", i), 64'(frame_done), 64'(tbl[i].fd));
            chk($sformatf("t%0d_fcnt", i), 64'(frame_cnt), 64'(tbl[i].fc));
            chk($sformatf("t%0d_lenerr", i), 64'(len_err), 64'(tbl[i].le));
            @(posedge axis_clk);
            #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b0; m_tready = 1'b0;

        // Pass-through, 1-cycle latency
        exp_len = 32'd400;
        m_tready = 1'b1;
        bad = 0;
        f0 = n_fd;
        for (int i = 1; i <= 400; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            s_tlast  = (i == 400);
            @(negedge axis_clk);
            if (!s_tready) bad++;
            if (i > 1 && !(m_tvalid && m_tdata == 32'(i - 1))) bad++;
            @(posedge axis_clk);
            #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge axis_clk);
        chk("pt_last_data", 64'(m_tdata), 64'(400));
        chk("pt_last_tlast", 64'(m_tlast), 64'(1));
        chk("pt_fdone_hi", 64'(frame_done), 64'(1));
        @(posedge axis_clk);
        #1;
        @(negedge axis_clk);
        chk("pt_stream_bad", 64'(bad), 64'(0));
        chk("pt_fdone_lo", 64'(frame_done), 64'(0));
        chk("pt_fdone_count", 64'(n_fd - f0), 64'(1));
        chk("pt_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("pt_len_err", 64'(len_err), 64'(0));
        @(posedge axis_clk);
        #1;

        // Backpressure fill
        m_tready = 1'b0;
        acc = 0;
        p0 = n_pop;
        for (int c = 0; c < 20; c++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(100 + acc);
            @(negedge axis_clk);
            r = s_tready;
            @(posedge axis_clk);
            if (r) acc++;
            #1;
        end
        s_tvalid = 1'b0;
        @(negedge axis_clk);
        chk("bp_accepted", 64'(acc), 64'(16));
        chk("bp_s_tready", 64'(s_tready), 64'(0));
        chk("bp_level", 64'(level), 64'(16));
        chk("bp_head_hold", 64'(m_tdata), 64'(100));
        @(posedge axis_clk);
        #1;
        m_tready = 1'b1;
        @(negedge axis_clk);
        chk("bp_ready_pop_cyc", 64'(s_tready), 64'(0));
        @(posedge axis_clk);
        #1;
        @(negedge axis_clk);
        chk("bp_ready_rise", 64'(s_tready), 64'(1));
        @(posedge axis_clk);
        #1;
        exp_len = 32'd20;
        for (int i = 16; i < 20; i++) push_word(32'(100 + i), i == 19);
        drain();
        chk("bp_pop_count", 64'(n_pop - p0), 64'(20));
        chk("bp_len_err", 64'(len_err), 64'(0));
        chk("bp_frame_cnt", 64'(frame_cnt), 64'(3));

        // Simultaneous push/pop at level 8 across pointer wrap
        m_tready = 1'b0;
        p0 = n_pop;
        for (int i = 0; i < 8; i++) push_word(32'(200 + i), 1'b0);
        m_tready = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(208 + k);
            @(negedge axis_clk);
            if (level != 5'd8 || !s_tready || !m_tvalid) bad++;
            @(posedge axis_clk);
            #1;
        end
        s_tvalid = 1'b0;
        @(negedge axis_clk);
        chk("sp_level_after", 64'(level), 64'(8));
        chk("sp_level_steady", 64'(bad), 64'(0));
        @(posedge axis_clk);
        #1;
        exp_len = 32'd19;
        push_word(32'd218, 1'b1);
        drain();
        chk("sp_pop_count", 64'(n_pop - p0), 64'(19));
        chk("sp_frame_cnt", 64'(frame_cnt), 64'(4));

        // Length error, sticky, then clr
        exp_len = 32'd400;
        m_tready = 1'b1;
        send_frame(399, 32'd1000);
        @(negedge axis_clk);
        chk("le_set", 64'(len_err), 64'(1));
        @(posedge axis_clk);
        #1;
        send_frame(400, 32'd2000);
        drain();
        chk("le_sticky", 64'(len_err), 64'(1));
        chk("le_frame_cnt", 64'(frame_cnt), 64'(6));
        clr = 1'b1;
        @(posedge axis_clk);
        #1;
        clr = 1'b0;
        @(negedge axis_clk);
        chk("clr_len_err", 64'(len_err), 64'(0));
        chk("clr_frame_cnt", 64'(frame_cnt), 64'(0));
        @(posedge axis_clk);
        #1;

        // Reset mid-frame
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(32'(3000 + i), 1'b0);
        axis_rst_n = 1'b0;
        @(posedge axis_clk);
        #1;
        @(negedge axis_clk);
        chk("mr_s_tready_rst", 64'(s_tready), 64'(0));
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        chk("mr_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("mr_level", 64'(level), 64'(0));
        chk("mr_rx_cnt", 64'(dut.r_rx_cnt), 64'(0));
        chk("mr_m_tdata", 64'(m_tdata), 64'(0));
        @(posedge axis_clk);
        #1;
        m_tready = 1'b1;
        send_frame(400, 32'd4000);
        drain();
        chk("mr_len_err", 64'(len_err), 64'(0));
        chk("mr_frame_cnt", 64'(frame_cnt), 64'(1));

        // FIR-rate input with random output stalls
        p0 = n_pop;
        done = 1'b0;
        fork
            begin
                for (int i = 1; i <= 400; i++) begin
                    push_word(32'(5000 + i), i == 400);
                    repeat (29) @(posedge axis_clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge axis_clk);
                    #1;
                    m_tready = ($urandom_range(0, 99) >= 30);
                end
            end
        join
        drain();
        chk("rs_pop_count", 64'(n_pop - p0), 64'(400));
        chk("rs_sb_empty", 64'(sbq.size()), 64'(0));
        chk("rs_len_err", 64'(len_err), 64'(0));
        chk("rs_frame_cnt", 64'(frame_cnt), 64'(2));
        chk("fd_total", 64'(n_fd), 64'(10));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
